// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel programmable clock divider with reconfiguration and lock tracking
module clkdiv_multi #(
  parameter int NCH      = 3,
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 16,
  parameter int LOCK_CYC = 16
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   ce,
  output logic             lock
);

  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    LOCKED  = 2'd1,
    RECONF  = 2'd2
  } state_t;

  localparam logic [3:0]       NCH_L     = 4'(NCH);
  localparam logic [15:0]      LOCK_LAST = 16'(LOCK_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W:0]   HALF_ONE  = (DIV_W+1)'(1);

  state_t           state;
  logic [15:0]      lock_cnt;
  logic [DIV_W-1:0] div    [NCH];
  logic [DIV_W-1:0] cnt    [NCH];
  logic [DIV_W-1:0] eff_d  [NCH];
  logic [DIV_W-1:0] last   [NCH];
  logic [DIV_W:0]   half   [NCH];
  logic             accept;
  logic             wr;
  logic [DIV_W-1:0] cfg_d;
  logic [DIV_W-1:0] cfg_cnt;

  assign accept  = cfg_valid && cfg_ready;
  // Requests to channels that do not exist are consumed without effect.
  assign wr      = accept && ({1'b0, cfg_ch} < NCH_L);
  assign cfg_d   = (cfg_div == '0) ? ONE : cfg_div;
  assign cfg_cnt = (cfg_phase < cfg_d) ? cfg_phase : '0;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      eff_d[i] = (div[i] == '0) ? ONE : div[i];
      last[i]  = eff_d[i] - ONE;
      half[i]  = ({1'b0, eff_d[i]} + HALF_ONE) >> 1;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        div[i] <= DIV_RST;
        cnt[i] <= '0;
      end
      ce     <= '0;
      clkout <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ce[i]     <= (cnt[i] == last[i]);
        clkout[i] <= ({1'b0, cnt[i]} < half[i]);
        if (wr && (cfg_ch == 3'(i))) begin
          div[i] <= cfg_div;
          cnt[i] <= cfg_cnt;
        end else begin
          cnt[i] <= (cnt[i] == last[i]) ? '0 : cnt[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= LOCKING;
      lock_cnt  <= '0;
      lock      <= 1'b0;
      cfg_ready <= 1'b1;
    end else if (wr) begin
      state     <= RECONF;
      lock_cnt  <= '0;
      lock      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      case (state)
        LOCKING: begin
          cfg_ready <= 1'b1;
          if (lock_cnt == LOCK_LAST) begin
            state <= LOCKED;
            lock  <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 16'd1;
          end
        end
        LOCKED: begin
          cfg_ready <= 1'b1;
          lock      <= 1'b1;
        end
        RECONF: begin
          state     <= LOCKING;
          lock_cnt  <= '0;
          lock      <= 1'b0;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= LOCKING;
          lock_cnt  <= '0;
          lock      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - randomized self-checking bench for clkdiv_multi against a timing-arithmetic model
module tb_clkdiv_multi;

  localparam int NCH      = 3;
  localparam int DIV_W    = 8;
  localparam int DIV_INIT = 16;
  localparam int LOCK_CYC = 16;

  logic             clkin;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic [NCH-1:0]   clkout;
  logic [NCH-1:0]   ce;
  logic             lock;

  int total = 0;
  int bad   = 0;

  // Model: each channel's count is (load value + edges since load) mod divisor.
  int m_div  [NCH];
  int m_ph   [NCH];
  int m_base [NCH];
  int last_wr;
  int n;
  logic [NCH-1:0] exp_clk;
  logic [NCH-1:0] exp_ce;

  clkdiv_multi #(
    .NCH(NCH), .DIV_W(DIV_W), .DIV_INIT(DIV_INIT), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clkin(clkin), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .clkout(clkout), .ce(ce), .lock(lock)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i]  = DIV_INIT;
      m_ph[i]   = 0;
      m_base[i] = 0;
    end
    last_wr = -1;
    n       = 0;
  endtask

  task automatic model_edge();
    bit ready_before;
    int d;
    int c;
    ready_before = ((n - 1) != last_wr);
    for (int i = 0; i < NCH; i++) begin
      d = (m_div[i] == 0) ? 1 : m_div[i];
      c = (m_ph[i] + (n - 1 - m_base[i])) % d;
      exp_ce[i]  = (c == d - 1);
      exp_clk[i] = (c < (d + 1) / 2);
    end
    if (cfg_valid && ready_before && (int'(cfg_ch) < NCH)) begin
      d = (int'(cfg_div) == 0) ? 1 : int'(cfg_div);
      m_div[cfg_ch]  = int'(cfg_div);
      m_ph[cfg_ch]   = (int'(cfg_phase) < d) ? int'(cfg_phase) : 0;
      m_base[cfg_ch] = n;
      last_wr        = n;
    end
  endtask

  task automatic step();
    @(posedge clkin);
    n++;
    model_edge();
    #1;
    check_eq("clkout", 32'(clkout), 32'(exp_clk));
    check_eq("ce", 32'(ce), 32'(exp_ce));
    check_eq("lock", 32'(lock), 32'(n >= last_wr + LOCK_CYC + 1));
    check_eq("cfg_ready", 32'(cfg_ready), 32'(n != last_wr));
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    cfg_valid = 1'b0;
    #1;
    check_eq("rst_clkout", 32'(clkout), 32'd0);
    check_eq("rst_ce", 32'(ce), 32'd0);
    check_eq("rst_lock", 32'(lock), 32'd0);
    check_eq("rst_ready", 32'(cfg_ready), 32'd1);
    repeat (cycles) @(posedge clkin);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_cfg(input int ch, input int dv, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_div   = DIV_W'(dv);
    cfg_phase = DIV_W'(ph);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    n         = 0;
    #2;
    do_reset(3);

    run(40);
    write_cfg(1, 5, 0);
    run(40);
    write_cfg(0, 0, 3);
    run(3);
    write_cfg(2, 1, 0);
    run(30);
    write_cfg(1, 6, 9);
    run(25);
    write_cfg(1, 6, 4);
    run(25);
    write_cfg(3, 7, 2);
    run(20);
    write_cfg(7, 2, 0);
    run(10);
    write_cfg(0, 4, 1);
    write_cfg(2, 9, 3);
    run(5);
    write_cfg(2, 9, 3);
    run(20);
    write_cfg(1, 5, 0);
    do_reset(1);
    run(50);
    write_cfg(0, 5, 2);
    step();
    do_reset(2);
    run(40);

    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        cfg_valid = ($urandom_range(0, 5) == 0);
        cfg_ch    = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 3));
        cfg_div   = ($urandom_range(0, 4) == 0) ? DIV_W'($urandom_range(0, 255))
                                                : DIV_W'($urandom_range(0, 12));
        cfg_phase = DIV_W'($urandom_range(0, 15));
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
